// File: rtl/sfft_pkg.sv
// Shared constants, state encoding and arithmetic helpers for the 8x8 SFFT.
// The twiddle tables and the round/saturate step are common to both passes.
package sfft_pkg;

  localparam int DW        = 12;
  localparam int TWF       = 10;
  localparam int N         = 8;
  localparam int M         = 8;
  localparam int ACC_W     = 2 * DW + 3;
  localparam int RND_SHIFT = 13;

  localparam logic signed [ACC_W-1:0] RND_ADD = ACC_W'(4096);
  localparam logic signed [ACC_W-1:0] SAT_HI  = ACC_W'(2047);
  localparam logic signed [ACC_W-1:0] SAT_LO  = -ACC_W'(2048);

  localparam logic signed [DW-1:0] TW_ONE = DW'(1 << TWF);
  localparam logic signed [DW-1:0] TW_R2  = DW'(724);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    ROW  = 2'd1,
    COL  = 2'd2,
    OUT  = 2'd3
  } state_t;

  function automatic logic signed [DW-1:0] cos_tab(input logic [2:0] t);
    case (t)
      3'd0:       return TW_ONE;
      3'd1, 3'd7: return TW_R2;
      3'd2, 3'd6: return '0;
      3'd3, 3'd5: return -TW_R2;
      default:    return -TW_ONE;
    endcase
  endfunction

  // sin(2*pi*t/8) == cos(2*pi*(t-2)/8); the 3-bit subtraction wraps mod 8
  function automatic logic signed [DW-1:0] sin_tab(input logic [2:0] t);
    return cos_tab(t - 3'd2);
  endfunction

  function automatic logic signed [DW-1:0] rnd_sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] q;
    q = (v + RND_ADD) >>> RND_SHIFT;
    if (q > SAT_HI) begin
      q = SAT_HI;
    end else if (q < SAT_LO) begin
      q = SAT_LO;
    end
    return q[DW-1:0];
  endfunction

endpackage

// File: rtl/sfft_cmac.sv
// Registered complex multiply-accumulate with clear-on-first-term.
// conj=1 multiplies by (c - js), conj=0 by (c + js); output is rounded/saturated.
module sfft_cmac
  import sfft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 conj,
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_im,
  input  logic signed [DW-1:0] c,
  input  logic signed [DW-1:0] s,
  output logic signed [DW-1:0] y_re,
  output logic signed [DW-1:0] y_im
);

  logic signed [2*DW-1:0]  p_rc, p_is, p_ic, p_rs;
  logic signed [ACC_W-1:0] term_re, term_im;
  logic signed [ACC_W-1:0] acc_re_reg, acc_im_reg;

  assign p_rc = (2*DW)'(a_re) * (2*DW)'(c);
  assign p_is = (2*DW)'(a_im) * (2*DW)'(s);
  assign p_ic = (2*DW)'(a_im) * (2*DW)'(c);
  assign p_rs = (2*DW)'(a_re) * (2*DW)'(s);

  assign term_re = conj ? (ACC_W'(p_rc) + ACC_W'(p_is)) : (ACC_W'(p_rc) - ACC_W'(p_is));
  assign term_im = conj ? (ACC_W'(p_ic) - ACC_W'(p_rs)) : (ACC_W'(p_ic) + ACC_W'(p_rs));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_re_reg <= '0;
      acc_im_reg <= '0;
    end else if (en) begin
      acc_re_reg <= (clr ? '0 : acc_re_reg) + term_re;
      acc_im_reg <= (clr ? '0 : acc_im_reg) + term_im;
    end
  end

  assign y_re = rnd_sat(acc_re_reg);
  assign y_im = rnd_sat(acc_im_reg);

endmodule

// File: rtl/sfft_8x8.sv
// Sequential 8x8 SFFT: load into buffer A, row pass A->B, column pass B->A, stream A out.
// One complex MAC; each output takes 8 accumulate cycles plus one writeback cycle.
module sfft_8x8
  import sfft_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_re,
  input  logic [DW-1:0] s_im,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_re,
  output logic [DW-1:0] m_im,
  output logic          m_last,
  output logic          busy
);

  localparam int PTS = N * M;

  state_t     state_reg;
  logic [5:0] load_cnt_reg;
  logic [5:0] out_idx_reg;
  logic [3:0] sub_reg;
  logic [6:0] out_ptr_reg;

  logic [2*DW-1:0] mem_a [PTS];
  logic [2*DW-1:0] mem_b [PTS];
  logic [2*DW-1:0] a_rd_data_reg, b_rd_data_reg;
  logic [5:0]      a_rd_addr, b_rd_addr;
  logic            a_we, b_we;
  logic [5:0]      a_waddr;
  logic [2*DW-1:0] a_wdata;

  logic       mac_en_reg, mac_clr_reg, row_pass_reg, wb_reg;
  logic [2:0] tw_idx_reg;
  logic [5:0] wb_addr_reg;

  logic [2:0] blk_hi, blk_lo, sub_lo, tw_idx;
  logic       in_pass, issue_acc, issue_wb, out_load;

  logic signed [DW-1:0] mac_a_re, mac_a_im, tw_c, tw_s, y_re, y_im;

  assign blk_hi    = out_idx_reg[5:3];
  assign blk_lo    = out_idx_reg[2:0];
  assign sub_lo    = sub_reg[2:0];
  assign in_pass   = (state_reg == ROW) || (state_reg == COL);
  assign issue_acc = in_pass && !sub_reg[3];
  assign issue_wb  = in_pass && sub_reg[3];
  // ROW: t = n*k, COL: t = m*l; 3-bit products give the mod-8 index directly
  assign tw_idx    = (state_reg == ROW) ? sub_lo * blk_hi : sub_lo * blk_lo;
  assign out_load  = (state_reg == OUT) && !out_ptr_reg[6] && (!m_valid || m_ready);

  // OUT keeps the RAM output register equal to A[out_ptr]: prefetch the next beat only when one is taken
  always_comb begin
    a_rd_addr = '0;
    if (state_reg == ROW) begin
      a_rd_addr = {sub_lo, blk_lo};
    end else if (state_reg == OUT) begin
      a_rd_addr = out_load ? out_ptr_reg[5:0] + 6'd1 : out_ptr_reg[5:0];
    end
  end

  assign b_rd_addr = {blk_hi, sub_lo};

  always_comb begin
    a_we    = 1'b0;
    a_waddr = load_cnt_reg;
    a_wdata = {s_re, s_im};
    if (state_reg == LOAD && s_valid && s_ready) begin
      a_we = 1'b1;
    end else if (wb_reg && !row_pass_reg) begin
      a_we    = 1'b1;
      a_waddr = wb_addr_reg;
      a_wdata = {y_re, y_im};
    end
  end

  assign b_we = wb_reg && row_pass_reg;

  always_ff @(posedge clk) begin
    if (a_we) begin
      mem_a[a_waddr] <= a_wdata;
    end
    a_rd_data_reg <= mem_a[a_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (b_we) begin
      mem_b[wb_addr_reg] <= {y_re, y_im};
    end
    b_rd_data_reg <= mem_b[b_rd_addr];
  end

  // MAC controls trail the read issue by one cycle to line up with the registered RAM data;
  // the last writeback of a pass therefore lands in the first cycle of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_en_reg   <= 1'b0;
      mac_clr_reg  <= 1'b0;
      row_pass_reg <= 1'b0;
      wb_reg       <= 1'b0;
      tw_idx_reg   <= '0;
      wb_addr_reg  <= '0;
    end else begin
      mac_en_reg   <= issue_acc;
      mac_clr_reg  <= issue_acc && (sub_reg == 4'd0);
      row_pass_reg <= (state_reg == ROW);
      wb_reg       <= issue_wb;
      tw_idx_reg   <= tw_idx;
      wb_addr_reg  <= out_idx_reg;
    end
  end

  assign mac_a_re = row_pass_reg ? a_rd_data_reg[2*DW-1:DW] : b_rd_data_reg[2*DW-1:DW];
  assign mac_a_im = row_pass_reg ? a_rd_data_reg[DW-1:0]    : b_rd_data_reg[DW-1:0];
  assign tw_c     = cos_tab(tw_idx_reg);
  assign tw_s     = sin_tab(tw_idx_reg);

  sfft_cmac u_cmac (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mac_en_reg),
    .clr   (mac_clr_reg),
    .conj  (row_pass_reg),
    .a_re  (mac_a_re),
    .a_im  (mac_a_im),
    .c     (tw_c),
    .s     (tw_s),
    .y_re  (y_re),
    .y_im  (y_im)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= LOAD;
      s_ready      <= 1'b1;
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
      m_re         <= '0;
      m_im         <= '0;
      busy         <= 1'b0;
      load_cnt_reg <= '0;
      out_idx_reg  <= '0;
      sub_reg      <= '0;
      out_ptr_reg  <= '0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (s_valid && s_ready) begin
            load_cnt_reg <= load_cnt_reg + 6'd1;
            if (load_cnt_reg == 6'(PTS - 1)) begin
              state_reg <= ROW;
              s_ready   <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end
        ROW, COL: begin
          if (sub_reg[3]) begin
            sub_reg     <= '0;
            out_idx_reg <= out_idx_reg + 6'd1;
            if (out_idx_reg == 6'(PTS - 1)) begin
              state_reg <= (state_reg == ROW) ? COL : OUT;
            end
          end else begin
            sub_reg <= sub_reg + 4'd1;
          end
        end
        OUT: begin
          if (m_valid && m_ready) begin
            m_valid <= 1'b0;
          end
          if (out_load) begin
            m_valid     <= 1'b1;
            m_re        <= a_rd_data_reg[2*DW-1:DW];
            m_im        <= a_rd_data_reg[DW-1:0];
            m_last      <= (out_ptr_reg[5:0] == 6'(PTS - 1));
            out_ptr_reg <= out_ptr_reg + 7'd1;
          end
          if (m_valid && m_ready && m_last) begin
            state_reg   <= LOAD;
            s_ready     <= 1'b1;
            busy        <= 1'b0;
            m_last      <= 1'b0;
            out_ptr_reg <= '0;
          end
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sfft_8x8.sv
// Randomized self-checking bench for sfft_8x8 against a direct double-sum DFT model
// using the same Q1.10 twiddles and per-pass round/saturate.
module tb_sfft_8x8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready;
  logic [11:0] s_re, s_im;
  logic        m_valid, m_ready;
  logic [11:0] m_re, m_im;
  logic        m_last, busy;

  always #5 clk = ~clk;

  sfft_8x8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_re    (s_re),
    .s_im    (s_im),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_re    (m_re),
    .m_im    (m_im),
    .m_last  (m_last),
    .busy    (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  int cos_t[8] = '{1024, 724, 0, -724, -1024, -724, 0, 724};
  int fx_re[64], fx_im[64];
  int exp_re[$], exp_im[$];
  string cur_tag = "reset";

  int  cyc = 0;
  int  frames_done = 0;
  int  out_j = 0;
  int  rdy_mode = 0;
  int  rdy_err = 0;
  int  last_out_cyc = 0;
  int  first_acc_cyc = 0;
  int  stp = 0;
  bit  hold_pend = 0;
  logic [11:0] hold_re, hold_im;
  bit  pat[4] = '{1, 0, 0, 1};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rs(input longint acc);
    longint q;
    q = (acc + 4096) >>> 13;
    if (q > 2047)  q = 2047;
    if (q < -2048) q = -2048;
    return int'(q);
  endfunction

  // X[k][l] = 1/64 sum_n sum_m x[n][m] e^{-j2pi nk/8} e^{+j2pi ml/8}, rounded after each 1-D sum
  task automatic model();
    int br[64], bi[64];
    longint ar, ai;
    int t, c, s;
    for (int k = 0; k < 8; k++) begin
      for (int m = 0; m < 8; m++) begin
        ar = 0; ai = 0;
        for (int n = 0; n < 8; n++) begin
          t = (n * k) % 8; c = cos_t[t]; s = cos_t[(t + 6) % 8];
          ar += longint'(fx_re[n*8+m]) * c + longint'(fx_im[n*8+m]) * s;
          ai += longint'(fx_im[n*8+m]) * c - longint'(fx_re[n*8+m]) * s;
        end
        br[k*8+m] = rs(ar);
        bi[k*8+m] = rs(ai);
      end
    end
    for (int k = 0; k < 8; k++) begin
      for (int l = 0; l < 8; l++) begin
        ar = 0; ai = 0;
        for (int m = 0; m < 8; m++) begin
          t = (m * l) % 8; c = cos_t[t]; s = cos_t[(t + 6) % 8];
          ar += longint'(br[k*8+m]) * c - longint'(bi[k*8+m]) * s;
          ai += longint'(bi[k*8+m]) * c + longint'(br[k*8+m]) * s;
        end
        exp_re.push_back(rs(ar));
        exp_im.push_back(rs(ai));
      end
    end
  endtask

  task automatic set_frame(input int kind);
    for (int i = 0; i < 64; i++) begin
      fx_re[i] = 0;
      fx_im[i] = 0;
      case (kind)
        1: fx_re[i] = 64;
        3: begin
          fx_re[i] = int'($urandom_range(0, 4095)) - 2048;
          fx_im[i] = int'($urandom_range(0, 4095)) - 2048;
        end
        4: begin
          fx_re[i] = int'($urandom_range(0, 600)) - 300;
          fx_im[i] = int'($urandom_range(0, 600)) - 300;
        end
        default: ;
      endcase
    end
    if (kind == 0) fx_re[0] = 256;
    if (kind == 2) fx_re[8] = 256;
  endtask

  task automatic send_frame();
    int w;
    model();
    for (int i = 0; i < 64; i++) begin
      s_valid = 1'b1;
      s_re = 12'(fx_re[i]);
      s_im = 12'(fx_im[i]);
      w = 0;
      while (!s_ready && w < 5000) begin
        @(posedge clk); #1;
        w++;
      end
      if (!s_ready) begin
        check({cur_tag, " s_ready timeout"}, 0, 1);
        s_valid = 1'b0;
        return;
      end
      if (i == 0) first_acc_cyc = cyc;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int w = 0;
    while (frames_done < target && w < 6000) begin
      @(posedge clk); #1;
      w++;
    end
    check({cur_tag, " frame done"}, longint'(frames_done >= target), 1);
  endtask

  // Output side: drives m_ready, consumes beats against the expected queue, checks stall hold
  initial begin
    int er, ei;
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      stp++;
      if (!rst_n) begin
        hold_pend = 0;
        out_j = 0;
      end
      if (hold_pend) begin
        check($sformatf("%s hold[%0d]", cur_tag, out_j), {m_valid, m_re, m_im}, {1'b1, hold_re, hold_im});
        hold_pend = 0;
      end
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = pat[stp % 4];
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (s_ready == busy) rdy_err++;
      if (m_valid && m_ready) begin
        if (exp_re.size() == 0) begin
          check({cur_tag, " spurious beat"}, 1, 0);
        end else begin
          er = exp_re.pop_front();
          ei = exp_im.pop_front();
          check($sformatf("%s re[%0d]", cur_tag, out_j), $signed(m_re), er);
          check($sformatf("%s im[%0d]", cur_tag, out_j), $signed(m_im), ei);
          check($sformatf("%s last[%0d]", cur_tag, out_j), m_last, longint'(out_j == 63));
          if (out_j == 63) begin
            out_j = 0;
            frames_done++;
            last_out_cyc = cyc;
            $display("frame %0d (%s) received, checks so far %0d", frames_done, cur_tag, total);
          end else begin
            out_j++;
          end
        end
      end else if (m_valid) begin
        hold_pend = 1;
        hold_re = m_re;
        hold_im = m_im;
      end
    end
  end

  initial begin
    int lat;
    rst_n = 1'b0; s_valid = 1'b0; s_re = '0; s_im = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst s_ready", s_ready, 1);
    check("rst m_valid", m_valid, 0);
    check("rst m_last", m_last, 0);
    check("rst m_re", m_re, 0);
    check("rst m_im", m_im, 0);
    check("rst busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    cur_tag = "impulse"; set_frame(0); send_frame();
    lat = 1;  // the cycle of the final input transfer counts as the first
    while (!m_valid && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 1154);
    wait_frames(1);

    cur_tag = "dc";      set_frame(1); send_frame(); wait_frames(2);
    cur_tag = "shift";   set_frame(2); send_frame(); wait_frames(3);
    rdy_mode = 2;
    cur_tag = "rand_fs"; set_frame(3); send_frame(); wait_frames(4);
    rdy_mode = 1;
    cur_tag = "dc_bp";   set_frame(1); send_frame(); wait_frames(5);
    rdy_mode = 0;

    rdy_err = 0;
    cur_tag = "b2b_a"; set_frame(4); send_frame();
    cur_tag = "b2b_b"; set_frame(3); send_frame();
    check("b2b load after m_last", longint'(first_acc_cyc > last_out_cyc), 1);
    wait_frames(7);
    check("b2b s_ready vs busy", rdy_err, 0);

    cur_tag = "abort"; set_frame(0); send_frame();
    repeat (799) @(posedge clk);
    #1;
    check("abort busy before reset", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort s_ready", s_ready, 1);
    check("abort m_valid", m_valid, 0);
    check("abort busy", busy, 0);
    exp_re.delete();
    exp_im.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    cur_tag = "post_rst"; set_frame(0); send_frame(); wait_frames(8);
    check("no leftover beats", exp_re.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
